// File: rtl/cv32e41p_rf_wb_arbiter.sv
// Generic FIFO for buffered writeback entries.
// Latency: an entry pushed in cycle N is visible at the head in cycle N+1 (no bypass).
// Backpressure: full/empty come from the registered count only; the caller must not push when full or pop when empty.
module cv32e41p_rf_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    assign empty    = (cnt == '0);
    assign full     = (cnt == FULL_CNT);
    assign head_dat = mem[rd_ptr];

    // Storage array; no reset needed because the count gates visibility.
    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap at DEPTH; count tracks occupancy independent of the payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            if (pop_vld)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            case ({push_vld, pop_vld})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push_vld && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop_vld && empty));
endmodule

// Writeback arbiter: maps LSU/ALU/APU results onto RF write ports A/B and tracks pending APU destinations.
// Latency: LSU/ALU reach the RF combinationally (0 cycles); APU results are buffered and written at least one cycle after push.
// Backpressure: LSU/ALU are never stalled; APU is held off by apu_ready_o (registered !full); the FIFO head waits while both ports are busy.
module cv32e41p_rf_wb_arbiter #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int FPU            = 0,
    parameter int ZFINX          = 0,
    parameter int APU_FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    input  logic                  alu_valid_i,
    input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
    input  logic [DATA_WIDTH-1:0] alu_wdata_i,
    input  logic                  apu_valid_i,
    input  logic [ADDR_WIDTH-1:0] apu_waddr_i,
    input  logic [DATA_WIDTH-1:0] apu_wdata_i,
    output logic                  apu_ready_o,
    input  logic                  apu_issue_i,
    input  logic [ADDR_WIDTH-1:0] apu_issue_waddr_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic                  hazard_a_o,
    output logic                  hazard_b_o,
    output logic                  hazard_c_o,
    output logic                  hazard_w_o,
    output logic                  rf_we_a_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_a_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_a_o,
    output logic                  rf_we_b_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_b_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_b_o,
    output logic                  apu_busy_o
);
    // Separate FP bank only when FP registers are not shared with the X bank.
    localparam int NREG = (FPU == 1 && ZFINX == 0) ? 64 : 32;
    localparam int IW   = (NREG == 64) ? 6 : 5;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_ent_t;

    wb_ent_t         push_ent;
    wb_ent_t         head;
    logic [$bits(wb_ent_t)-1:0] head_raw;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic            head_to_a;
    logic            head_to_b;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    // Addresses outside the tracked range never hit the scoreboard.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ((a >> IW) == '0);
    endfunction

    function automatic logic pend_hit(input logic [NREG-1:0] p, input logic [ADDR_WIDTH-1:0] a);
        return in_range(a) && p[a[IW-1:0]];
    endfunction

    assign push_ent    = '{addr: apu_waddr_i, data: apu_wdata_i};
    assign fifo_push   = apu_valid_i && apu_ready_o;
    assign apu_ready_o = !fifo_full;
    assign head        = wb_ent_t'(head_raw);

    cv32e41p_rf_wb_fifo #(
        .WIDTH ($bits(wb_ent_t)),
        .DEPTH (APU_FIFO_DEPTH)
    ) u_apu_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (fifo_push),
        .push_dat (push_ent),
        .pop_vld  (fifo_pop),
        .head_dat (head_raw),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Port steering: ALU owns A, LSU owns B; the FIFO head takes A first, else B when only ALU is active.
    always_comb begin
        head_to_a    = 1'b0;
        head_to_b    = 1'b0;
        rf_we_a_o    = 1'b0;
        rf_waddr_a_o = '0;
        rf_wdata_a_o = '0;
        rf_we_b_o    = 1'b0;
        rf_waddr_b_o = '0;
        rf_wdata_b_o = '0;
        if (rst_n) begin
            head_to_a = !fifo_empty && !alu_valid_i;
            head_to_b = !fifo_empty && alu_valid_i && !lsu_valid_i;
            if (alu_valid_i) begin
                rf_we_a_o    = 1'b1;
                rf_waddr_a_o = alu_waddr_i;
                rf_wdata_a_o = alu_wdata_i;
            end else if (head_to_a) begin
                rf_we_a_o    = 1'b1;
                rf_waddr_a_o = head.addr;
                rf_wdata_a_o = head.data;
            end
            if (lsu_valid_i) begin
                rf_we_b_o    = 1'b1;
                rf_waddr_b_o = lsu_waddr_i;
                rf_wdata_b_o = lsu_wdata_i;
            end else if (head_to_b) begin
                rf_we_b_o    = 1'b1;
                rf_waddr_b_o = head.addr;
                rf_wdata_b_o = head.data;
            end
        end
    end

    assign fifo_pop = head_to_a || head_to_b;

    // Scoreboard next state: clear on head write, then set on issue so a same-cycle set wins; x0 is never tracked.
    always_comb begin
        pending_nxt = pending;
        if (fifo_pop && in_range(head.addr))
            pending_nxt[head.addr[IW-1:0]] = 1'b0;
        if (apu_issue_i && in_range(apu_issue_waddr_i) && (apu_issue_waddr_i[IW-1:0] != '0))
            pending_nxt[apu_issue_waddr_i[IW-1:0]] = 1'b1;
    end

    // Scoreboard register; reset discards all outstanding destinations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

    assign hazard_a_o = pend_hit(pending, raddr_a_i);
    assign hazard_b_o = pend_hit(pending, raddr_b_i);
    assign hazard_c_o = pend_hit(pending, raddr_c_i);
    assign hazard_w_o = (apu_issue_i && pend_hit(pending, apu_issue_waddr_i)) ||
                        (alu_valid_i && pend_hit(pending, alu_waddr_i)) ||
                        (lsu_valid_i && pend_hit(pending, lsu_waddr_i));
    assign apu_busy_o = !fifo_empty || (|pending);

    a_no_same_addr: assert property (@(posedge clk) disable iff (!rst_n)
        !(rf_we_a_o && rf_we_b_o && (rf_waddr_a_o == rf_waddr_b_o)));
endmodule

// File: tb/tb_cv32e41p_rf_wb_arbiter.sv
module tb_cv32e41p_rf_wb_arbiter;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lsu_valid, alu_valid, apu_valid, apu_issue;
    logic [AW-1:0] lsu_waddr, alu_waddr, apu_waddr, apu_issue_waddr;
    logic [DW-1:0] lsu_wdata, alu_wdata, apu_wdata;
    logic [AW-1:0] raddr_a, raddr_b, raddr_c;
    logic          apu_ready_o, hazard_a_o, hazard_b_o, hazard_c_o, hazard_w_o;
    logic          rf_we_a_o, rf_we_b_o, apu_busy_o;
    logic [AW-1:0] rf_waddr_a_o, rf_waddr_b_o;
    logic [DW-1:0] rf_wdata_a_o, rf_wdata_b_o;

    int vectors = 0;
    int miscompares = 0;

    ent_t        mq[$];
    logic [31:0] pend = '0;

    cv32e41p_rf_wb_arbiter #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .FPU (0), .ZFINX (0), .APU_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lsu_valid_i       (lsu_valid),
        .lsu_waddr_i       (lsu_waddr),
        .lsu_wdata_i       (lsu_wdata),
        .alu_valid_i       (alu_valid),
        .alu_waddr_i       (alu_waddr),
        .alu_wdata_i       (alu_wdata),
        .apu_valid_i       (apu_valid),
        .apu_waddr_i       (apu_waddr),
        .apu_wdata_i       (apu_wdata),
        .apu_ready_o       (apu_ready_o),
        .apu_issue_i       (apu_issue),
        .apu_issue_waddr_i (apu_issue_waddr),
        .raddr_a_i         (raddr_a),
        .raddr_b_i         (raddr_b),
        .raddr_c_i         (raddr_c),
        .hazard_a_o        (hazard_a_o),
        .hazard_b_o        (hazard_b_o),
        .hazard_c_o        (hazard_c_o),
        .hazard_w_o        (hazard_w_o),
        .rf_we_a_o         (rf_we_a_o),
        .rf_waddr_a_o      (rf_waddr_a_o),
        .rf_wdata_a_o      (rf_wdata_a_o),
        .rf_we_b_o         (rf_we_b_o),
        .rf_waddr_b_o      (rf_waddr_b_o),
        .rf_wdata_b_o      (rf_wdata_b_o),
        .apu_busy_o        (apu_busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
        alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
        apu_valid = 1'b0; apu_waddr = '0; apu_wdata = '0;
        apu_issue = 1'b0; apu_issue_waddr = '0;
        raddr_a = '0; raddr_b = '0; raddr_c = '0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Compare every output against the scoreboard, then commit this cycle's model update.
    task automatic advance();
        ent_t          head;
        logic          has_head, h2a, h2b, acc;
        logic          ewa, ewb;
        logic [AW-1:0] eaa, eab;
        logic [DW-1:0] eda, edb;
        if (!rst_n) begin
            mq.delete();
            pend = '0;
        end
        has_head = rst_n && (mq.size() != 0);
        head = '{addr: '0, data: '0};
        if (has_head) head = mq[0];
        h2a = has_head && !alu_valid;
        h2b = has_head && alu_valid && !lsu_valid;
        ewa = 1'b0; eaa = '0; eda = '0;
        ewb = 1'b0; eab = '0; edb = '0;
        if (rst_n && alu_valid) begin ewa = 1'b1; eaa = alu_waddr; eda = alu_wdata; end
        else if (h2a)           begin ewa = 1'b1; eaa = head.addr; eda = head.data; end
        if (rst_n && lsu_valid) begin ewb = 1'b1; eab = lsu_waddr; edb = lsu_wdata; end
        else if (h2b)           begin ewb = 1'b1; eab = head.addr; edb = head.data; end
        chk("we_a", 32'(rf_we_a_o), 32'(ewa));
        chk("waddr_a", 32'(rf_waddr_a_o), 32'(eaa));
        chk("wdata_a", rf_wdata_a_o, eda);
        chk("we_b", 32'(rf_we_b_o), 32'(ewb));
        chk("waddr_b", 32'(rf_waddr_b_o), 32'(eab));
        chk("wdata_b", rf_wdata_b_o, edb);
        chk("apu_ready", 32'(apu_ready_o), 32'(mq.size() < DEPTH));
        chk("apu_busy", 32'(apu_busy_o), 32'((mq.size() != 0) || (pend != '0)));
        chk("hazard_a", 32'(hazard_a_o), 32'(pend[raddr_a[4:0]]));
        chk("hazard_b", 32'(hazard_b_o), 32'(pend[raddr_b[4:0]]));
        chk("hazard_c", 32'(hazard_c_o), 32'(pend[raddr_c[4:0]]));
        chk("hazard_w", 32'(hazard_w_o),
            32'((apu_issue && pend[apu_issue_waddr[4:0]]) ||
                (alu_valid && pend[alu_waddr[4:0]]) ||
                (lsu_valid && pend[lsu_waddr[4:0]])));
        if (rst_n) begin
            acc = apu_valid && (mq.size() < DEPTH);
            if (h2a || h2b) begin
                void'(mq.pop_front());
                pend[head.addr[4:0]] = 1'b0;
            end
            if (apu_issue && apu_issue_waddr[4:0] != 5'd0) pend[apu_issue_waddr[4:0]] = 1'b1;
            if (acc) mq.push_back('{addr: apu_waddr, data: apu_wdata});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    initial begin
        idle();
        // Reset state.
        step();
        step();
        rst_n = 1'b1;

        // LSU and ALU in the same cycle land on B and A with zero latency.
        lsu_valid = 1'b1; lsu_waddr = 6'd5; lsu_wdata = 32'hA;
        alu_valid = 1'b1; alu_waddr = 6'd6; alu_wdata = 32'hB;
        settle();
        chk("t1_waddr_b", 32'(rf_waddr_b_o), 32'd5);
        chk("t1_wdata_a", rf_wdata_a_o, 32'hB);
        advance();
        idle();

        // APU result for x7 waits behind busy ports, then drains onto A.
        apu_issue = 1'b1; apu_issue_waddr = 6'd7;
        step();
        idle();
        alu_valid = 1'b1; alu_waddr = 6'd1; alu_wdata = 32'h1;
        lsu_valid = 1'b1; lsu_waddr = 6'd2; lsu_wdata = 32'h2;
        apu_valid = 1'b1; apu_waddr = 6'd7; apu_wdata = 32'hC;
        raddr_a = 6'd7;
        settle();
        chk("t2_hazard_a", 32'(hazard_a_o), 32'd1);
        advance();
        apu_valid = 1'b0;
        step();
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        settle();
        chk("t2_waddr_a", 32'(rf_waddr_a_o), 32'd7);
        chk("t2_wdata_a", rf_wdata_a_o, 32'hC);
        advance();
        settle();
        chk("t2_hazard_cleared", 32'(hazard_a_o), 32'd0);
        advance();
        idle();

        // Fill the FIFO, observe backpressure, then drain in order (B first, then A).
        alu_valid = 1'b1; alu_waddr = 6'd3; alu_wdata = 32'h3;
        lsu_valid = 1'b1; lsu_waddr = 6'd4; lsu_wdata = 32'h4;
        apu_valid = 1'b1; apu_waddr = 6'd9;  apu_wdata = 32'h11;
        step();
        apu_waddr = 6'd10; apu_wdata = 32'h22;
        step();
        apu_waddr = 6'd11; apu_wdata = 32'h33;
        settle();
        chk("t3_ready_full", 32'(apu_ready_o), 32'd0);
        advance();
        apu_valid = 1'b0; lsu_valid = 1'b0;
        settle();
        chk("t3_head_on_b", 32'(rf_waddr_b_o), 32'd9);
        chk("t3_ready_lag", 32'(apu_ready_o), 32'd0);
        advance();
        alu_valid = 1'b0;
        settle();
        chk("t3_ready_back", 32'(apu_ready_o), 32'd1);
        chk("t3_second_a", rf_wdata_a_o, 32'h22);
        advance();
        idle();
        step();

        // Issue to x8 while the older x8 result is written: pending bit survives.
        apu_issue = 1'b1; apu_issue_waddr = 6'd8;
        step();
        apu_issue = 1'b0;
        apu_valid = 1'b1; apu_waddr = 6'd8; apu_wdata = 32'h88;
        step();
        apu_valid = 1'b0;
        apu_issue = 1'b1;
        settle();
        chk("t4_old_x8_write", 32'(rf_waddr_a_o), 32'd8);
        advance();
        settle();
        chk("t4_hazard_w", 32'(hazard_w_o), 32'd1);
        advance();
        apu_issue = 1'b0;
        apu_valid = 1'b1; apu_waddr = 6'd8; apu_wdata = 32'h99;
        step();
        idle();
        step();
        step();

        // Issue to x0 never sets a pending bit.
        apu_issue = 1'b1; apu_issue_waddr = 6'd0;
        step();
        idle();
        settle();
        chk("t5_hazard_x0", 32'(hazard_a_o), 32'd0);
        chk("t5_busy", 32'(apu_busy_o), 32'd0);
        advance();

        // Reset with two buffered results: nothing is written and state is flushed.
        alu_valid = 1'b1; alu_waddr = 6'd3; alu_wdata = 32'h3;
        lsu_valid = 1'b1; lsu_waddr = 6'd4; lsu_wdata = 32'h4;
        apu_valid = 1'b1; apu_waddr = 6'd12; apu_wdata = 32'h12;
        apu_issue = 1'b1; apu_issue_waddr = 6'd12;
        step();
        apu_waddr = 6'd13; apu_wdata = 32'h13; apu_issue_waddr = 6'd13;
        step();
        apu_valid = 1'b0; apu_issue = 1'b0;
        rst_n = 1'b0;
        settle();
        chk("t6_rst_we_a", 32'(rf_we_a_o), 32'd0);
        chk("t6_rst_we_b", 32'(rf_we_b_o), 32'd0);
        advance();
        step();
        rst_n = 1'b1;
        idle();
        settle();
        chk("t6_busy_after", 32'(apu_busy_o), 32'd0);
        chk("t6_ready_after", 32'(apu_ready_o), 32'd1);
        chk("t6_no_write", 32'(rf_we_a_o), 32'd0);
        advance();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
